frame_sum_unit: RTL and testbench

//  Upstream framing stage of the 8-bit accumulator datapath. Accepts 8-bit samples over
//  a valid/ready handshake and sums exactly FRAME_LEN accepted samples into a wide register.

---
 rtl/frame_sum_unit_if.sv | 25 ++
 rtl/frame_sum_unit.sv | 99 +++++++++
 tb/tb_frame_sum_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/frame_sum_unit_if.sv
// Handshake bundle for frame_sum_unit: sample input, frame output and the flush control.
// The master side drives samples and takes frames; the slave side is the summing unit.
interface frame_sum_unit_if #(
  parameter int SUM_W = 12
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       data_in;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic             overflow;
  logic [7:0]       frame_cnt;

  modport master (
    output clear, in_valid, data_in, out_ready,
    input  in_ready, out_valid, out_sum, overflow, frame_cnt
  );

  modport slave (
    input  clear, in_valid, data_in, out_ready,
    output in_ready, out_valid, out_sum, overflow, frame_cnt
  );
endinterface

// File: rtl/frame_sum_unit.sv
// Sums FRAME_LEN accepted 8-bit samples, then holds the frame sum on a valid/ready output
// until taken. Tracks per-frame overflow (wrap or clamp) and a wrapping completed-frame count.
module frame_sum_unit #(
  parameter int FRAME_LEN = 4,
  parameter int SUM_W     = 12,
  parameter bit SATURATE  = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  frame_sum_unit_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] out_sum_q;
  logic             ovf_acc_q;
  logic             ovf_out_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [7:0]       frame_cnt_q;

  logic [SUM_W:0]   add_full;
  logic [SUM_W-1:0] sum_d;
  logic             ovf_d;

  // One extra bit on the adder exposes the carry that marks overflow.
  always_comb begin
    add_full = {1'b0, sum_q} + {{(SUM_W - 7){1'b0}}, bus.data_in};
    sum_d    = add_full[SUM_W-1:0];
    if (add_full[SUM_W] && SATURATE) begin
      sum_d = {SUM_W{1'b1}};
    end
    ovf_d = ovf_acc_q | add_full[SUM_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_sum_q   <= '0;
      ovf_acc_q   <= 1'b0;
      ovf_out_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else if (bus.clear) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      sum_q       <= '0;
      ovf_acc_q   <= 1'b0;
      ovf_out_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.in_valid && in_ready_q) begin
            sum_q     <= sum_d;
            ovf_acc_q <= ovf_d;
            if (cnt_q == LAST_CNT) begin
              cnt_q       <= '0;
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_sum_q   <= sum_d;
              ovf_out_q   <= ovf_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // Handoff: output stays registered, so the next frame starts a cycle later.
          if (bus.out_ready && out_valid_q) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            sum_q       <= '0;
            ovf_acc_q   <= 1'b0;
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.overflow  = ovf_out_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_frame_sum_unit.sv
// Directed bench for frame_sum_unit: one default unit plus two 9-bit units (wrap and clamp).
// Each step drives inputs #1 after a rising edge and checks outputs at that same point.
module tb_frame_sum_unit;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  frame_sum_unit_if #(.SUM_W(12)) ia ();
  frame_sum_unit_if #(.SUM_W(9))  ib ();
  frame_sum_unit_if #(.SUM_W(9))  ic ();

  frame_sum_unit #(.FRAME_LEN(4), .SUM_W(12), .SATURATE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  frame_sum_unit #(.FRAME_LEN(4), .SUM_W(9),  .SATURATE(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  frame_sum_unit #(.FRAME_LEN(4), .SUM_W(9),  .SATURATE(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    ia.clear = 1'b0; ia.in_valid = 1'b0; ia.data_in = 8'h00; ia.out_ready = 1'b0;
    ib.clear = 1'b0; ib.in_valid = 1'b0; ib.data_in = 8'h00; ib.out_ready = 1'b0;
    ic.clear = 1'b0; ic.in_valid = 1'b0; ic.data_in = 8'h00; ic.out_ready = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready",  32'(ia.in_ready),  32'h1);
    chk("rst_out_valid", 32'(ia.out_valid), 32'h0);
    chk("rst_out_sum",   32'(ia.out_sum),   32'h0);
    chk("rst_frame_cnt", 32'(ia.frame_cnt), 32'h0);
    chk("rst_overflow",  32'(ia.overflow),  32'h0);

    // 9-bit units: four 0xFF samples, wrap vs clamp; left holding in HOLD
    ib.in_valid = 1'b1; ib.data_in = 8'hFF;
    ic.in_valid = 1'b1; ic.data_in = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    ib.in_valid = 1'b0; ic.in_valid = 1'b0;
    chk("wrap_valid", 32'(ib.out_valid), 32'h1);
    chk("wrap_sum",   32'(ib.out_sum),   32'h1FC);
    chk("wrap_ovf",   32'(ib.overflow),  32'h1);
    chk("sat_sum",    32'(ic.out_sum),   32'h1FF);
    chk("sat_ovf",    32'(ic.overflow),  32'h1);

    // Back-to-back frame with out_ready=1
    ia.out_ready = 1'b1;
    ia.in_valid = 1'b1;
    ia.data_in = 8'hAA; tick();
    ia.data_in = 8'hAF; tick();
    ia.data_in = 8'hEA; tick();
    chk("b2b_no_early_valid", 32'(ia.out_valid), 32'h0);
    ia.data_in = 8'h01; tick();
    ia.in_valid = 1'b0;
    chk("b2b_valid",    32'(ia.out_valid), 32'h1);
    chk("b2b_sum",      32'(ia.out_sum),   32'h244);
    chk("b2b_ovf",      32'(ia.overflow),  32'h0);
    chk("b2b_in_ready", 32'(ia.in_ready),  32'h0);
    tick();
    chk("b2b_taken_valid", 32'(ia.out_valid), 32'h0);
    chk("b2b_frame_cnt",   32'(ia.frame_cnt), 32'h1);
    chk("b2b_in_ready2",   32'(ia.in_ready),  32'h1);

    // Backpressure: HOLD for 5 cycles with in_valid=1 and a sample waiting
    ia.out_ready = 1'b0;
    ia.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ia.data_in = 8'(i);
      tick();
    end
    ia.data_in = 8'h55;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",    32'(ia.out_valid), 32'h1);
      chk("bp_in_ready", 32'(ia.in_ready),  32'h0);
      chk("bp_sum",      32'(ia.out_sum),   32'hA);
      tick();
    end
    ia.out_ready = 1'b1;
    tick();
    ia.out_ready = 1'b0;
    chk("bp_taken_valid", 32'(ia.out_valid), 32'h0);
    chk("bp_frame_cnt",   32'(ia.frame_cnt), 32'h2);
    tick();
    ia.data_in = 8'h01;
    for (int i = 0; i < 3; i++) tick();
    ia.in_valid = 1'b0;
    chk("bp_next_sum",   32'(ia.out_sum),   32'h58);
    chk("bp_next_valid", 32'(ia.out_valid), 32'h1);
    tick();
    chk("bp_once_frame_cnt", 32'(ia.frame_cnt), 32'h2);
    ia.out_ready = 1'b1;
    tick();
    chk("bp_next_cnt", 32'(ia.frame_cnt), 32'h3);

    // Clear abandons a partial frame and the sample offered with it
    ia.in_valid = 1'b1;
    ia.data_in = 8'h10; tick();
    ia.data_in = 8'h20; tick();
    ia.clear = 1'b1; ia.data_in = 8'h30; tick();
    ia.clear = 1'b0;
    chk("clr_frame_cnt", 32'(ia.frame_cnt), 32'h3);
    chk("clr_in_ready",  32'(ia.in_ready),  32'h1);
    chk("clr_valid",     32'(ia.out_valid), 32'h0);
    ia.data_in = 8'h01;
    for (int i = 0; i < 4; i++) tick();
    ia.in_valid = 1'b0;
    chk("clr_sum",   32'(ia.out_sum),   32'h004);
    chk("clr_valid2", 32'(ia.out_valid), 32'h1);
    tick();
    chk("clr_frame_cnt2", 32'(ia.frame_cnt), 32'h4);

    // Zero-sample frames until frame_cnt wraps (each frame takes 5 cycles)
    ia.in_valid = 1'b1;
    ia.data_in = 8'h00;
    for (int i = 0; i < 251 * 5; i++) tick();
    chk("wrap_cnt_255", 32'(ia.frame_cnt), 32'hFF);
    for (int i = 0; i < 5; i++) tick();
    chk("wrap_cnt_0",  32'(ia.frame_cnt), 32'h0);
    chk("wrap_zero_sum", 32'(ia.out_sum), 32'h0);

    // Reset while in HOLD
    ia.out_ready = 1'b0;
    ia.data_in = 8'h80;
    for (int i = 0; i < 4; i++) tick();
    ia.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(ia.out_valid), 32'h1);
    chk("pre_rst_sum",   32'(ia.out_sum),   32'h200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hold_rst_valid",    32'(ia.out_valid), 32'h0);
    chk("hold_rst_in_ready", 32'(ia.in_ready),  32'h1);
    chk("hold_rst_sum",      32'(ia.out_sum),   32'h0);
    chk("hold_rst_cnt",      32'(ia.frame_cnt), 32'h0);
    chk("hold_rst_ovf_b",    32'(ib.overflow),  32'h0);
    chk("hold_rst_sum_c",    32'(ic.out_sum),   32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
